// File: rtl/wos_pkg.sv
// Shared types and helpers for the weighted-order-statistics rank sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package wos_pkg;

  // Controller states: accept a window, rank it sample by sample, pick, present
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RANK   = 2'd1,
    ST_SELECT = 2'd2,
    ST_OUT    = 2'd3
  } wos_state_t;

  // Median rank used after reset: (N+1)/2
  function automatic int default_rank(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/rank_counter.sv
// Compare-and-count for one sample: rank = 1 + samples ordered before sample k.
// Latency: combinational.
// Backpressure: none; the caller steps k one sample per cycle.
module rank_counter #(
  parameter int N         = 7,
  parameter int DATA_BITS = 8,
  parameter int RANK_BITS = $clog2(N + 1),
  parameter int CNT_BITS  = (N > 1) ? $clog2(N) : 1
) (
  input  logic [DATA_BITS*N-1:0] i_samples,
  input  logic [CNT_BITS-1:0]    i_k,
  output logic [RANK_BITS-1:0]   o_rank
);

  logic [DATA_BITS-1:0] w_s [N];
  logic [DATA_BITS-1:0] w_sk;

  // Unpack the window and pick out the sample currently being ranked
  always_comb begin
    w_sk = '0;
    for (int i = 0; i < N; i++) begin
      w_s[i] = i_samples[DATA_BITS*i +: DATA_BITS];
      if (i_k == CNT_BITS'(i)) begin
        w_sk = w_s[i];
      end
    end
  end

  // Count strictly smaller samples plus equal ones at a lower index, so ties
  // resolve toward the lower index and the ranks form a permutation of 1..N
  always_comb begin
    o_rank = RANK_BITS'(1);
    for (int j = 0; j < N; j++) begin
      if (CNT_BITS'(j) != i_k) begin
        if ((w_s[j] < w_sk) || ((w_s[j] == w_sk) && (CNT_BITS'(j) < i_k))) begin
          o_rank = o_rank + RANK_BITS'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rank_selector.sv
// Returns the sample whose rank matches the requested rank.
// Latency: combinational.
// Backpressure: none; output is 0 if no rank matches.
module rank_selector #(
  parameter int N         = 7,
  parameter int DATA_BITS = 8,
  parameter int RANK_BITS = $clog2(N + 1)
) (
  input  logic [DATA_BITS*N-1:0] i_samples,
  input  logic [RANK_BITS*N-1:0] i_ranks,
  input  logic [RANK_BITS-1:0]   i_sel_rank,
  output logic [DATA_BITS-1:0]   o_data
);

  // Ranks are unique, so at most one sample matches
  always_comb begin
    o_data = '0;
    for (int i = 0; i < N; i++) begin
      if (i_ranks[RANK_BITS*i +: RANK_BITS] == i_sel_rank) begin
        o_data = i_samples[DATA_BITS*i +: DATA_BITS];
      end
    end
  end

endmodule

// File: rtl/wos_rank_sequencer.sv
// Sequential WOS controller: ranks an N-sample window one sample per cycle, selects the configured rank.
// Latency: N+1 cycles from input accept to out_valid; N+3 cycles per window with out_ready high.
// Backpressure: in_ready is low from accept until the result handshakes; result is held while out_ready is low.
module wos_rank_sequencer
  import wos_pkg::*;
#(
  parameter int N         = 7,
  parameter int DATA_BITS = 8,
  parameter int RANK_BITS = $clog2(N + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [RANK_BITS-1:0]   cfg_rank,
  output logic                   cfg_err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_BITS*N-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_BITS-1:0]   out_data,
  output logic                   busy
);

  localparam int CNT_BITS = (N > 1) ? $clog2(N) : 1;
  localparam logic [RANK_BITS-1:0] DEF_RANK = RANK_BITS'(default_rank(N));
  localparam logic [CNT_BITS-1:0]  LAST_K   = CNT_BITS'(N - 1);

  wos_state_t             r_state;
  logic [DATA_BITS*N-1:0] r_samples;
  logic [RANK_BITS-1:0]   r_ranks [N];
  logic [CNT_BITS-1:0]    r_k;
  logic [RANK_BITS-1:0]   r_active_rank;
  logic [RANK_BITS-1:0]   r_shadow_rank;
  logic                   r_cfg_err;
  logic                   r_out_vld;
  logic [DATA_BITS-1:0]   r_out_dat;

  logic [RANK_BITS-1:0]   w_rank;
  logic [RANK_BITS*N-1:0] w_ranks_flat;
  logic [DATA_BITS-1:0]   w_sel_dat;
  logic                   w_cfg_ok;

  // Flatten the rank registers for the selector
  always_comb begin
    w_ranks_flat = '0;
    for (int i = 0; i < N; i++) begin
      w_ranks_flat[RANK_BITS*i +: RANK_BITS] = r_ranks[i];
    end
  end

  // Legal ranks are 1..N; the extra bit keeps the upper-bound compare meaningful
  always_comb begin
    w_cfg_ok = (cfg_rank != '0) && ({1'b0, cfg_rank} <= (RANK_BITS + 1)'(N));
  end

  rank_counter #(
    .N         (N),
    .DATA_BITS (DATA_BITS),
    .RANK_BITS (RANK_BITS),
    .CNT_BITS  (CNT_BITS)
  ) u_rank_counter (
    .i_samples (r_samples),
    .i_k       (r_k),
    .o_rank    (w_rank)
  );

  rank_selector #(
    .N         (N),
    .DATA_BITS (DATA_BITS),
    .RANK_BITS (RANK_BITS)
  ) u_rank_selector (
    .i_samples  (r_samples),
    .i_ranks    (w_ranks_flat),
    .i_sel_rank (r_active_rank),
    .o_data     (w_sel_dat)
  );

  // Shadow rank register: accepts legal writes in any state, flags illegal ones for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_rank <= DEF_RANK;
      r_cfg_err     <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      if (cfg_we) begin
        if (w_cfg_ok) begin
          r_shadow_rank <= cfg_rank;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end
    end
  end

  // Window FSM: capture, rank one sample per cycle, select, hold until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_samples     <= '0;
      r_k           <= '0;
      r_active_rank <= '0;
      r_out_vld     <= 1'b0;
      r_out_dat     <= '0;
      for (int i = 0; i < N; i++) begin
        r_ranks[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            // The shadow is sampled before any same-cycle write lands
            r_samples     <= in_data;
            r_active_rank <= r_shadow_rank;
            r_k           <= '0;
            r_state       <= ST_RANK;
          end
        end
        ST_RANK: begin
          for (int i = 0; i < N; i++) begin
            if (r_k == CNT_BITS'(i)) begin
              r_ranks[i] <= w_rank;
            end
          end
          // The index stops at N-1 rather than wrapping; it is cleared on the next accept
          if (r_k == LAST_K) begin
            r_state <= ST_SELECT;
          end else begin
            r_k <= r_k + CNT_BITS'(1);
          end
        end
        ST_SELECT: begin
          r_out_dat <= w_sel_dat;
          r_out_vld <= 1'b1;
          r_state   <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_vld <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RANK) || (r_state == ST_SELECT);
  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign cfg_err   = r_cfg_err;

endmodule
